mem_ctrl: RTL and testbench

//  CPU-side memory controller: turns 32-bit instruction-fetch and load/store requests into byte-serial

---
 rtl/mem_ctrl_if.sv | 28 ++
 rtl/mem_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mem_ctrl.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// CPU-side memory controller bundle: fetch/LSU request channels plus the 8-bit RAM/HCI bus.
interface mem_ctrl_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        ls_req;
    logic        ls_we;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata, mem_din,
        input  if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
    );

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata, mem_din,
        output if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: 32-bit fetch/load/store requests onto the 8-bit RAM/HCI bus.
// Latency after acceptance: read n bytes -> done at +n+2, write n bytes -> done at +n+1.
// rdy_in=0 freezes everything; a read replays the byte lost in flight, a write re-presents its byte.
module mem_ctrl #(
    parameter int IO_SEL_HI = 17
) (
    input  logic      clk_in,
    input  logic      rst_in,
    input  logic      rdy_in,
    mem_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state;
    logic [31:0] base;
    logic [31:0] wdata;
    logic [31:0] rbuf;
    logic [2:0]  n;
    logic [2:0]  iss;
    logic [2:0]  rcv;
    logic        is_ls;
    logic        pres;
    logic        infl;

    logic        take_ls;
    logic        take_if;
    logic [31:0] req_addr;
    logic [2:0]  req_n;
    logic [2:0]  iss_nxt;
    logic [31:0] rbuf_cap;
    logic        last_cap;

    always_comb begin
        take_ls  = rdy_in && bus.ls_req;
        take_if  = rdy_in && !bus.ls_req && bus.if_req;
        req_addr = bus.ls_req ? bus.ls_addr : bus.if_addr;
        req_n    = 3'd4;
        if (bus.ls_req) begin
            case (bus.ls_size)
                2'b00:   req_n = 3'd1;
                2'b01:   req_n = 3'd2;
                default: req_n = 3'd4;
            endcase
        end
        // IO devices only decode single bytes; never let a wider access spill into neighbours
        if (req_addr[IO_SEL_HI -: 2] == 2'b11) req_n = 3'd1;
        iss_nxt  = iss + 3'd1;
        rbuf_cap = rbuf;
        rbuf_cap[{rcv[1:0], 3'b000} +: 8] = bus.mem_din;
        last_cap = infl && (rcv + 3'd1 == n);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state        <= IDLE;
            base         <= '0;
            wdata        <= '0;
            rbuf         <= '0;
            n            <= '0;
            iss          <= '0;
            rcv          <= '0;
            is_ls        <= 1'b0;
            pres         <= 1'b0;
            infl         <= 1'b0;
            bus.mem_a    <= '0;
            bus.mem_dout <= '0;
            bus.mem_wr   <= 1'b0;
            bus.if_done  <= 1'b0;
            bus.ls_done  <= 1'b0;
            bus.if_data  <= '0;
            bus.ls_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_ls || take_if) begin
                        base      <= req_addr;
                        n         <= req_n;
                        wdata     <= bus.ls_wdata;
                        is_ls     <= take_ls;
                        rbuf      <= '0;
                        rcv       <= '0;
                        infl      <= 1'b0;
                        bus.mem_a <= req_addr;
                        if (take_ls && bus.ls_we) begin
                            state        <= WRITE;
                            iss          <= '0;
                            bus.mem_dout <= bus.ls_wdata[7:0];
                            bus.mem_wr   <= 1'b1;
                        end else begin
                            state <= READ;
                            iss   <= 3'd1;
                            pres  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (rdy_in) begin
                        // the address on the bus this cycle really went out; its byte arrives next cycle
                        infl <= pres;
                        if (infl) begin
                            rbuf <= rbuf_cap;
                            rcv  <= rcv + 3'd1;
                        end
                        if (last_cap) begin
                            state     <= DONE;
                            pres      <= 1'b0;
                            bus.mem_a <= '0;
                            if (is_ls) begin
                                bus.ls_done  <= 1'b1;
                                bus.ls_rdata <= rbuf_cap;
                            end else begin
                                bus.if_done <= 1'b1;
                                bus.if_data <= rbuf_cap;
                            end
                        end else if (iss < n) begin
                            bus.mem_a <= base + 32'(iss);
                            iss       <= iss_nxt;
                            pres      <= 1'b1;
                        end else begin
                            pres      <= 1'b0;
                            bus.mem_a <= '0;
                        end
                    end else begin
                        // HCI owned the bus: drop the byte in flight and park on the first missing one
                        infl      <= 1'b0;
                        pres      <= 1'b1;
                        iss       <= rcv + 3'd1;
                        bus.mem_a <= base + 32'(rcv);
                    end
                end
                WRITE: begin
                    if (!rdy_in) begin
                        bus.mem_wr <= 1'b0;
                    end else if (!bus.mem_wr) begin
                        bus.mem_wr <= 1'b1;
                    end else if (iss_nxt == n) begin
                        state        <= DONE;
                        iss          <= iss_nxt;
                        bus.mem_wr   <= 1'b0;
                        bus.mem_a    <= '0;
                        bus.mem_dout <= '0;
                        bus.ls_done  <= 1'b1;
                    end else begin
                        iss          <= iss_nxt;
                        bus.mem_a    <= base + 32'(iss_nxt);
                        bus.mem_dout <= wdata[{iss_nxt[1:0], 3'b000} +: 8];
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    bus.if_done <= 1'b0;
                    bus.ls_done <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte-wide RAM model on the bus, directed timing scenarios, randomized traffic vs a memory model.
module tb_mem_ctrl;
    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
    mem_ctrl_if bus();

    mem_ctrl #(.IO_SEL_HI(17)) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .rdy_in(rdy_in),
        .bus   (bus)
    );

    always #5 clk_in = ~clk_in;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    logic [7:0] ram     [1024];
    logic [7:0] ref_mem [1024];
    int         wr_cnt  [1024];
    bit         sync_en = 1'b0;

    // RAM answers one cycle after the address; while HCI owns the bus the read mux returns junk
    always @(posedge clk_in) begin
        if (sync_en) begin
            for (int i = 0; i < 1024; i++) begin
                ram[i]    <= ref_mem[i];
                wr_cnt[i] <= 0;
            end
        end else if (rdy_in && bus.mem_wr) begin
            ram[bus.mem_a[9:0]]    <= bus.mem_dout;
            wr_cnt[bus.mem_a[9:0]] <= wr_cnt[bus.mem_a[9:0]] + 1;
        end
        bus.mem_din <= rdy_in ? ram[bus.mem_a[9:0]] : 8'($urandom);
    end

    task automatic step();
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    task automatic sync_ram();
        sync_en = 1'b1;
        step();
        sync_en = 1'b0;
    endtask

    function automatic int size_bytes(input bit ls, input logic [1:0] sz);
        if (!ls) return 4;
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr, input int nb);
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < nb; k++) v[8*k +: 8] = ref_mem[10'(addr + 32'(k))];
        return v;
    endfunction

    task automatic model_write(input logic [31:0] addr, input int nb, input logic [31:0] wd);
        for (int k = 0; k < nb; k++) ref_mem[10'(addr + 32'(k))] = wd[8*k +: 8];
    endtask

    // Starts in a fresh cycle, holds the request until its done pulse, drops it in the done cycle.
    task automatic do_access(input bit ls, input bit we, input logic [1:0] sz, input logic [31:0] addr,
                             input logic [31:0] wd, input int pause_pct,
                             output logic [31:0] data, output int lat, output bit got);
        int  t0;
        bit  accepted;
        step();
        if (ls) begin
            bus.ls_req = 1'b1; bus.ls_we = we; bus.ls_size = sz; bus.ls_addr = addr; bus.ls_wdata = wd;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = addr;
        end
        got = 1'b0; accepted = 1'b0; lat = 0; data = '0; t0 = cyc;
        for (int i = 0; i < 300 && !got; i++) begin
            rdy_in = (pause_pct == 0) || ($urandom_range(99) >= pause_pct);
            if (!accepted && rdy_in) begin
                accepted = 1'b1;
                t0 = cyc;
            end
            step();
            if (ls ? bus.ls_done : bus.if_done) begin
                got  = 1'b1;
                lat  = cyc - t0;
                data = ls ? bus.ls_rdata : bus.if_data;
                bus.ls_req = 1'b0;
                bus.if_req = 1'b0;
            end
        end
        rdy_in = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({bus.mem_a, bus.mem_dout, bus.mem_wr, bus.if_done, bus.ls_done, bus.if_data, bus.ls_rdata} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: mem_a=%h dout=%h wr=%b ifd=%b lsd=%b if_data=%h ls_rdata=%h, want all 0",
                     bus.mem_a, bus.mem_dout, bus.mem_wr, bus.if_done, bus.ls_done, bus.if_data, bus.ls_rdata);
        end
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
    endtask

    task automatic test_word_fetch();
        ref_mem[10'h100] = 8'h11; ref_mem[10'h101] = 8'h22; ref_mem[10'h102] = 8'h33; ref_mem[10'h103] = 8'h44;
        sync_ram();
        bus.if_req = 1'b1; bus.if_addr = 32'h100; rdy_in = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k <= 4) begin
                total++;
                if (bus.mem_a !== 32'(32'h100 + k - 1) || bus.mem_wr !== 1'b0) begin
                    bad++;
                    $display("FAIL fetch_addr T+%0d: mem_a=%h wr=%b, want %h wr=0", k, bus.mem_a, bus.mem_wr, 32'h100 + k - 1);
                end
            end
            total++;
            if (bus.if_done !== (k == 6)) begin
                bad++;
                $display("FAIL fetch_done T+%0d: if_done=%b want %b", k, bus.if_done, k == 6);
            end
        end
        total++;
        if (bus.if_data !== 32'h4433_2211) begin
            bad++;
            $display("FAIL fetch_data: got %h want 44332211", bus.if_data);
        end
        bus.if_req = 1'b0;
        step();
        total++;
        if (bus.if_done !== 1'b0 || bus.mem_a !== 32'h0) begin
            bad++;
            $display("FAIL fetch_pulse: if_done=%b mem_a=%h after done, want 0 0", bus.if_done, bus.mem_a);
        end
    endtask

    task automatic test_half_store();
        logic [31:0] data;
        int          lat;
        bit          got;
        logic [7:0]  keep;
        logic [40:0] exp_bus [1:2];
        exp_bus[1] = {32'h202, 8'hEF, 1'b1};
        exp_bus[2] = {32'h203, 8'hBE, 1'b1};
        sync_ram();
        keep = ref_mem[10'h204];
        bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_size = 2'b01; bus.ls_addr = 32'h202; bus.ls_wdata = 32'h1234_BEEF;
        for (int k = 1; k <= 3; k++) begin
            step();
            if (k <= 2) begin
                total++;
                if ({bus.mem_a, bus.mem_dout, bus.mem_wr} !== exp_bus[k]) begin
                    bad++;
                    $display("FAIL store_bus T+%0d: a=%h d=%h wr=%b want %h", k, bus.mem_a, bus.mem_dout, bus.mem_wr, exp_bus[k]);
                end
            end
            total++;
            if (bus.ls_done !== (k == 3)) begin
                bad++;
                $display("FAIL store_done T+%0d: ls_done=%b want %b", k, bus.ls_done, k == 3);
            end
        end
        bus.ls_req = 1'b0;
        step();
        total++;
        if (ram[10'h202] !== 8'hEF || ram[10'h203] !== 8'hBE || ram[10'h204] !== keep) begin
            bad++;
            $display("FAIL store_ram: got %h %h %h want EF BE %h", ram[10'h202], ram[10'h203], ram[10'h204], keep);
        end
        model_write(32'h202, 2, 32'h1234_BEEF);
        do_access(1'b1, 1'b0, 2'b01, 32'h202, 32'h0, 0, data, lat, got);
        total++;
        if (!got || data !== 32'h0000_BEEF) begin
            bad++;
            $display("FAIL store_readback: got=%b data=%h want 1 0000beef", got, data);
        end
    endtask

    task automatic test_priority();
        logic [31:0] exp_f;
        ref_mem[10'h10] = 8'h5A;
        for (int k = 0; k < 4; k++) ref_mem[10'h20 + 10'(k)] = 8'($urandom);
        exp_f = model_read(32'h20, 4);
        sync_ram();
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_size = 2'b00; bus.ls_addr = 32'h10;
        bus.if_req = 1'b1; bus.if_addr = 32'h20;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 1 || k == 5) begin
                total++;
                if (bus.mem_a !== ((k == 1) ? 32'h10 : 32'h20)) begin
                    bad++;
                    $display("FAIL prio_addr T+%0d: mem_a=%h want %h", k, bus.mem_a, (k == 1) ? 32'h10 : 32'h20);
                end
            end
            if (k <= 4) begin
                total++;
                if (bus.ls_done !== (k == 3) || bus.if_done !== 1'b0) begin
                    bad++;
                    $display("FAIL prio_done T+%0d: ls_done=%b if_done=%b want %b 0", k, bus.ls_done, bus.if_done, k == 3);
                end
            end
            if (k == 3) begin
                total++;
                if (bus.ls_rdata !== 32'h0000_005A) begin
                    bad++;
                    $display("FAIL prio_ldata: got %h want 0000005a", bus.ls_rdata);
                end
                bus.ls_req = 1'b0;
            end
            if (k >= 9) begin
                total++;
                if (bus.if_done !== (k == 10)) begin
                    bad++;
                    $display("FAIL prio_fetch_done T+%0d: if_done=%b want %b", k, bus.if_done, k == 10);
                end
            end
        end
        total++;
        if (bus.if_data !== exp_f) begin
            bad++;
            $display("FAIL prio_fetch_data: got %h want %h", bus.if_data, exp_f);
        end
        bus.if_req = 1'b0;
        step();
    endtask

    task automatic test_read_pause();
        logic [31:0] exp_d;
        for (int k = 0; k < 4; k++) ref_mem[10'h300 + 10'(k)] = 8'($urandom);
        exp_d = model_read(32'h300, 4);
        sync_ram();
        bus.if_req = 1'b1; bus.if_addr = 32'h300; rdy_in = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 7 || k == 8) begin
                total++;
                if (bus.mem_a !== 32'(32'h300 + k - 5)) begin
                    bad++;
                    $display("FAIL pause_reissue T+%0d: mem_a=%h want %h", k, bus.mem_a, 32'h300 + k - 5);
                end
            end
            total++;
            if (bus.if_done !== (k == 10)) begin
                bad++;
                $display("FAIL pause_done T+%0d: if_done=%b want %b", k, bus.if_done, k == 10);
            end
            rdy_in = !(k >= 4 && k <= 6);
        end
        total++;
        if (bus.if_data !== exp_d) begin
            bad++;
            $display("FAIL pause_data: got %h want %h", bus.if_data, exp_d);
        end
        bus.if_req = 1'b0;
        rdy_in = 1'b1;
        step();
    endtask

    task automatic test_write_pause();
        logic [31:0] wd;
        bit          got;
        int          once;
        wd = $urandom;
        sync_ram();
        bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_size = 2'b10; bus.ls_addr = 32'h400; bus.ls_wdata = wd;
        got = 1'b0;
        for (int k = 1; k <= 30 && !got; k++) begin
            step();
            // the strobe in the first paused cycle was launched before the pause was visible
            if (k == 4 || k == 5) begin
                total++;
                if (bus.mem_wr !== 1'b0) begin
                    bad++;
                    $display("FAIL wpause_wr T+%0d: mem_wr=%b while paused, want 0", k, bus.mem_wr);
                end
            end
            if (bus.ls_done === 1'b1) got = 1'b1;
            rdy_in = !(k >= 3 && k <= 5);
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL wpause_timeout: ls_done=%b want 1 within 30 cycles", got);
        end
        bus.ls_req = 1'b0;
        rdy_in = 1'b1;
        step();
        once = 0;
        for (int k = 0; k < 4; k++) if (wr_cnt[10'h400 + 10'(k)] == 1) once++;
        total++;
        if (once != 4) begin
            bad++;
            $display("FAIL wpause_once: %0d of 4 bytes written exactly once, want 4", once);
        end
        total++;
        if ({ram[10'h403], ram[10'h402], ram[10'h401], ram[10'h400]} !== wd) begin
            bad++;
            $display("FAIL wpause_ram: got %h want %h", {ram[10'h403], ram[10'h402], ram[10'h401], ram[10'h400]}, wd);
        end
        model_write(32'h400, 4, wd);
    endtask

    task automatic test_reset_mid();
        logic [31:0] data, wd;
        int          lat;
        bit          got;
        sync_ram();
        bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_size = 2'b10; bus.ls_addr = 32'h500; bus.ls_wdata = 32'hDEAD_BEEF;
        step();
        step();
        #3;
        rst_in = 1'b1;
        #1;
        total++;
        if (bus.mem_wr !== 1'b0 || bus.mem_a !== 32'h0) begin
            bad++;
            $display("FAIL rst_mid_wr: mem_wr=%b mem_a=%h right after reset, want 0 0", bus.mem_wr, bus.mem_a);
        end
        bus.ls_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            total++;
            if (bus.ls_done !== 1'b0) begin
                bad++;
                $display("FAIL rst_mid_done: ls_done=%b during reset, want 0", bus.ls_done);
            end
        end
        rst_in = 1'b0;
        wd = $urandom;
        do_access(1'b1, 1'b1, 2'b10, 32'h500, wd, 0, data, lat, got);
        total++;
        if (!got || lat != 5) begin
            bad++;
            $display("FAIL rst_fresh_store: got=%b lat=%0d want 1 5", got, lat);
        end
        model_write(32'h500, 4, wd);
        do_access(1'b0, 1'b0, 2'b00, 32'h500, 32'h0, 0, data, lat, got);
        total++;
        if (!got || data !== wd) begin
            bad++;
            $display("FAIL rst_fresh_read: got=%b data=%h want 1 %h", got, data, wd);
        end
    endtask

    task automatic test_random(input int pause_pct, input int iters);
        bit          ls, we, got;
        logic [1:0]  sz;
        logic [31:0] addr, wd, data, exp_d;
        int          nb, lat;
        for (int i = 0; i < iters; i++) begin
            ls    = ($urandom_range(1) == 1);
            we    = ls && ($urandom_range(1) == 1);
            sz    = 2'($urandom_range(3));
            addr  = $urandom & 32'hFFFC_FFFF;
            wd    = $urandom;
            nb    = size_bytes(ls, sz);
            exp_d = model_read(addr, nb);
            do_access(ls, we, sz, addr, wd, pause_pct, data, lat, got);
            total++;
            if (!got) begin
                bad++;
                $display("FAIL rand_timeout[%0d]: no done for addr=%h ls=%b we=%b", i, addr, ls, we);
            end else if (we) begin
                model_write(addr, nb, wd);
                if (pause_pct == 0) begin
                    total++;
                    if (lat != nb + 1) begin
                        bad++;
                        $display("FAIL rand_wlat[%0d]: latency %0d want %0d", i, lat, nb + 1);
                    end
                end
            end else begin
                total++;
                if (data !== exp_d) begin
                    bad++;
                    $display("FAIL rand_rdata[%0d]: addr=%h n=%0d got %h want %h", i, addr, nb, data, exp_d);
                end
                if (pause_pct == 0) begin
                    total++;
                    if (lat != nb + 2) begin
                        bad++;
                        $display("FAIL rand_rlat[%0d]: latency %0d want %0d", i, lat, nb + 2);
                    end
                end
            end
        end
    endtask

    initial begin
        int diffs;
        rst_in = 1'b1; rdy_in = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_size = '0; bus.ls_addr = '0; bus.ls_wdata = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'($urandom);
        test_reset();
        test_word_fetch();
        test_half_store();
        test_priority();
        test_read_pause();
        test_write_pause();
        test_reset_mid();
        sync_ram();
        test_random(0, 40);
        test_random(25, 40);
        step();
        diffs = 0;
        for (int i = 0; i < 1024; i++) if (ram[i] !== ref_mem[i]) diffs++;
        total++;
        if (diffs != 0) begin
            bad++;
            $display("FAIL final_ram: %0d bytes differ from model, want 0", diffs);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
